// File: rtl/sap1_pkg.sv
// sap1_pkg: opcodes, one-hot T-states and control-word bit positions for the SAP-1 sequencer
package sap1_pkg;
  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'he;
  localparam logic [3:0] OP_HLT = 4'hf;
  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } tstate_e;
  localparam int CW_CP = 0;
  localparam int CW_EP = 1;
  localparam int CW_LM = 2;
  localparam int CW_ER = 3;
  localparam int CW_LI = 4;
  localparam int CW_EI = 5;
  localparam int CW_LA = 6;
  localparam int CW_EA = 7;
  localparam int CW_SU = 8;
  localparam int CW_EU = 9;
  localparam int CW_LB = 10;
  localparam int CW_LO = 11;
  localparam int CW_W  = 12;
  // Load/increment strobes must fire only on the cycle the state actually advances
  localparam logic [CW_W-1:0] CW_STROBES = CW_W'((1 << CW_CP) | (1 << CW_LM) | (1 << CW_LI) |
                                                 (1 << CW_LA) | (1 << CW_LB) | (1 << CW_LO));
endpackage

// File: rtl/sap1_controller_sequencer_if.sv
// sap1_controller_sequencer_if: run/step/opcode inputs and control-word outputs of the SAP-1 sequencer
interface sap1_controller_sequencer_if #(parameter int OpcodeWidth = 4);
  logic                   i_run;
  logic                   i_step;
  logic [OpcodeWidth-1:0] i_opcode;
  logic [5:0]             o_tstate;
  logic o_cp, o_ep, o_lm, o_er, o_li, o_ei, o_la, o_ea, o_su, o_eu, o_lb, o_lo, o_halted;
  modport master (
    input  i_run, i_step, i_opcode,
    output o_tstate, o_cp, o_ep, o_lm, o_er, o_li, o_ei, o_la, o_ea, o_su, o_eu, o_lb, o_lo, o_halted
  );
  modport slave (
    output i_run, i_step, i_opcode,
    input  o_tstate, o_cp, o_ep, o_lm, o_er, o_li, o_ei, o_la, o_ea, o_su, o_eu, o_lb, o_lo, o_halted
  );
endinterface

// File: rtl/sap1_ring_counter.sv
// sap1_ring_counter: one-hot T1..T6 ring with advance enable and early return to T1
module sap1_ring_counter
  import sap1_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    adv,
  input  logic    ret,
  output tstate_e tstate_q
);
  tstate_e tstate_d;
  always_comb tstate_d = !adv ? tstate_q : ret ? T1 : tstate_e'({tstate_q[4:0], tstate_q[5]});
  always_ff @(posedge clk or posedge rst)
    if (rst) tstate_q <= T1;
    else     tstate_q <= tstate_d;
endmodule

// File: rtl/sap1_controller_sequencer.sv
// sap1_controller_sequencer: SAP-1 T-state sequencer and microcode decode with run/step/halt.
// SAP1_VARIABLE_CYCLE_EN returns to T1 right after each instruction's last active state.
module sap1_controller_sequencer
  import sap1_pkg::*;
#(
  parameter int OpcodeWidth = 4
) (
  input logic                          i_clk,
  input logic                          i_rst,
  sap1_controller_sequencer_if.master  bus
);
  logic step_q, step_d, halted_q, halted_d;
  logic adv, ring_adv, ret, hlt_hit;
  logic is_lda, is_add, is_sub, is_out, is_hlt, is_mem;
  logic [CW_W-1:0] cw, cw_g;
  tstate_e t;
  sap1_ring_counter u_ring (
    .clk(i_clk), .rst(i_rst), .adv(ring_adv), .ret(ret), .tstate_q(t)
  );
  always_comb begin
    is_lda   = bus.i_opcode == OpcodeWidth'(OP_LDA);
    is_add   = bus.i_opcode == OpcodeWidth'(OP_ADD);
    is_sub   = bus.i_opcode == OpcodeWidth'(OP_SUB);
    is_out   = bus.i_opcode == OpcodeWidth'(OP_OUT);
    is_hlt   = bus.i_opcode == OpcodeWidth'(OP_HLT);
    is_mem   = is_lda | is_add | is_sub;
    adv      = !halted_q && (bus.i_run || (bus.i_step && !step_q));
    hlt_hit  = t == T4 && is_hlt;
    ring_adv = adv && !hlt_hit;
    step_d   = bus.i_step;
    halted_d = halted_q || hlt_hit;
`ifdef SAP1_VARIABLE_CYCLE_EN
    ret = (t == T3 && !(is_mem | is_out | is_hlt)) || (t == T4 && is_out) || (t == T5 && is_lda);
`else
    ret = 1'b0;
`endif
    cw = '0;
    case (t)
      T1: begin cw[CW_EP] = 1'b1; cw[CW_LM] = 1'b1; end
      T2: cw[CW_CP] = 1'b1;
      T3: begin cw[CW_ER] = 1'b1; cw[CW_LI] = 1'b1; end
      T4: begin cw[CW_EI] = is_mem; cw[CW_LM] = is_mem; cw[CW_EA] = is_out; cw[CW_LO] = is_out; end
      T5: begin cw[CW_ER] = is_mem; cw[CW_LA] = is_lda; cw[CW_LB] = is_add | is_sub; end
      T6: begin cw[CW_EU] = is_add | is_sub; cw[CW_LA] = is_add | is_sub; cw[CW_SU] = is_sub; end
      default: cw = '0;
    endcase
    cw_g = (i_rst || halted_q) ? '0 : adv ? cw : cw & ~CW_STROBES;
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      step_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  assign bus.o_tstate = t;
  assign bus.o_halted = halted_q;
  assign bus.o_cp = cw_g[CW_CP];
  assign bus.o_ep = cw_g[CW_EP];
  assign bus.o_lm = cw_g[CW_LM];
  assign bus.o_er = cw_g[CW_ER];
  assign bus.o_li = cw_g[CW_LI];
  assign bus.o_ei = cw_g[CW_EI];
  assign bus.o_la = cw_g[CW_LA];
  assign bus.o_ea = cw_g[CW_EA];
  assign bus.o_su = cw_g[CW_SU];
  assign bus.o_eu = cw_g[CW_EU];
  assign bus.o_lb = cw_g[CW_LB];
  assign bus.o_lo = cw_g[CW_LO];
endmodule

// File: tb/tb_sap1_controller_sequencer.sv
// tb_sap1_controller_sequencer: directed checks of fetch/execute microcode, stepping, halt and reset
module tb_sap1_controller_sequencer;
  localparam logic [11:0] CP = 12'h001, EP = 12'h002, LM = 12'h004, ER = 12'h008;
  localparam logic [11:0] LI = 12'h010, EI = 12'h020, LA = 12'h040, EA = 12'h080;
  localparam logic [11:0] SU = 12'h100, EU = 12'h200, LB = 12'h400, LO = 12'h800;
  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int bad = 0;
  logic [11:0] ctl;
  logic [11:0] lda_c [7];
  logic [5:0]  lda_t [7];
  sap1_controller_sequencer_if #(.OpcodeWidth(4)) bus ();
  sap1_controller_sequencer #(.OpcodeWidth(4)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));
  always #5 clk = ~clk;
  assign ctl = {bus.o_lo, bus.o_lb, bus.o_eu, bus.o_su, bus.o_ea, bus.o_la,
                bus.o_ei, bus.o_li, bus.o_er, bus.o_lm, bus.o_ep, bus.o_cp};
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic restart(input logic [3:0] op, input logic run);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    bus.i_opcode = op;
    bus.i_run = run;
    bus.i_step = 1'b0;
    #1;
  endtask
  initial begin
    rst = 1'b1;
    bus.i_run = 1'b0;
    bus.i_step = 1'b0;
    bus.i_opcode = 4'h0;
    tick();
    check("rst_t", 16'(bus.o_tstate), 16'h01);
    check("rst_ctl", 16'(ctl), 16'h0);
    check("rst_halt", 16'(bus.o_halted), 16'h0);
    bus.i_run = 1'b1;
    #1;
    check("rst_run_ctl", 16'(ctl), 16'h0);
    lda_t = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h01};
    lda_c = '{EP | LM, CP, ER | LI, EI | LM, ER | LA, 12'h0, EP | LM};
`ifdef SAP1_VARIABLE_CYCLE_EN
    lda_t[5] = 6'h01; lda_c[5] = EP | LM;
    lda_t[6] = 6'h02; lda_c[6] = CP;
`endif
    restart(4'h0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      check($sformatf("lda_t%0d", i), 16'(bus.o_tstate), 16'(lda_t[i]));
      check($sformatf("lda_c%0d", i), 16'(ctl), 16'(lda_c[i]));
      tick();
    end
    restart(4'h2, 1'b1);
    repeat (4) tick();
    check("sub_t5", 16'(ctl), 16'(ER | LB));
    tick();
    check("sub_t6_t", 16'(bus.o_tstate), 16'h20);
    check("sub_t6", 16'(ctl), 16'(SU | EU | LA));
    restart(4'h1, 1'b1);
    repeat (5) tick();
    check("add_t6", 16'(ctl), 16'(EU | LA));
    restart(4'hf, 1'b1);
    repeat (3) tick();
    check("hlt_t4_t", 16'(bus.o_tstate), 16'h08);
    check("hlt_t4_c", 16'(ctl), 16'h0);
    check("hlt_t4_h", 16'(bus.o_halted), 16'h0);
    tick();
    check("hlt_set", 16'(bus.o_halted), 16'h1);
    for (int i = 0; i < 20; i++) begin
      bus.i_step = ~bus.i_step;
      #1;
      check("hlt_hold_t", 16'(bus.o_tstate), 16'h08);
      check("hlt_hold_c", 16'(ctl), 16'h0);
      check("hlt_hold_h", 16'(bus.o_halted), 16'h1);
      tick();
    end
    restart(4'h0, 1'b0);
    check("step_idle_c", 16'(ctl), 16'(EP));
    bus.i_step = 1'b1;
    #1;
    check("step_edge_c", 16'(ctl), 16'(EP | LM));
    repeat (5) tick();
    check("step_once_t", 16'(bus.o_tstate), 16'h02);
    check("step_held_c", 16'(ctl), 16'h0);
    bus.i_step = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("step_wait_c", 16'(ctl), 16'h0);
    end
    check("step_wait_t", 16'(bus.o_tstate), 16'h02);
    bus.i_step = 1'b1;
    #1;
    check("step_cp", 16'(ctl), 16'(CP));
    tick();
    check("step_t3_t", 16'(bus.o_tstate), 16'h04);
    check("step_t3_c", 16'(ctl), 16'(ER));
    restart(4'h1, 1'b1);
    repeat (4) tick();
    check("arst_pre_t", 16'(bus.o_tstate), 16'h10);
    check("arst_pre_c", 16'(ctl), 16'(ER | LB));
    rst = 1'b1;
    #1;
    check("arst_c", 16'(ctl), 16'h0);
    check("arst_t", 16'(bus.o_tstate), 16'h01);
    tick();
    rst = 1'b0;
    #1;
    check("arst_rel_t", 16'(bus.o_tstate), 16'h01);
    check("arst_rel_c", 16'(ctl), 16'(EP | LM));
    restart(4'he, 1'b1);
    repeat (3) tick();
    check("out_t4", 16'(ctl), 16'(EA | LO));
    tick();
`ifdef SAP1_VARIABLE_CYCLE_EN
    check("out_ret_t", 16'(bus.o_tstate), 16'h01);
    check("out_ret_c", 16'(ctl), 16'(EP | LM));
`else
    check("out_t5_t", 16'(bus.o_tstate), 16'h10);
    check("out_t5_c", 16'(ctl), 16'h0);
    tick();
    check("out_t6_t", 16'(bus.o_tstate), 16'h20);
    check("out_t6_c", 16'(ctl), 16'h0);
    tick();
    check("out_wrap_t", 16'(bus.o_tstate), 16'h01);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
